// File: rtl/memory_request_unit.sv
// Memory request sequencer: fetch/data handshake with the caches, PC-advance strobe, LL/SC link register.
// Build option: define LINK_SNOOP_EN to let coherence invalidates clear a matching link (multicore build).
//
// state | meaning
// FETCH | instruction read outstanding; retire non-memory instructions and failed SCs on ihit
// DATA  | data read/write outstanding until dhit
// HALT  | core stopped; only reset leaves

module memory_request_unit #(
  parameter int ADDR_W   = 32,
  parameter int WORD_LSB = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ihit,
  input  logic              dhit,
  input  logic              dR_REQ,
  input  logic              dW_REQ,
  input  logic              datomic,
  input  logic              halt,
  input  logic [ADDR_W-1:0] dmemaddr,
  input  logic              ccinv,
  input  logic [ADDR_W-1:0] ccsnoopaddr,
  output logic              imemREN,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic              pc_en,
  output logic              sc_result,
  output logic              link_valid,
  output logic              halted
);

  typedef enum logic [1:0] {FETCH, DATA, HALT} state_t;

  state_t                     state_q, state_d;
  logic                       dmem_ren_q, dmem_ren_d;
  logic                       dmem_wen_q, dmem_wen_d;
  logic                       atomic_q, atomic_d;
  logic                       halted_q, halted_d;
  logic                       link_valid_q, link_valid_d;
  logic [ADDR_W-1:WORD_LSB]   link_addr_q, link_addr_d;

  logic link_ok;
  logic ll_done;
  logic sc_retire;
  logic snoop_link_hit;
  logic snoop_new_hit;

  assign link_ok = link_valid_q && (link_addr_q == dmemaddr[ADDR_W-1:WORD_LSB]);

`ifdef LINK_SNOOP_EN
  // snoop_new_hit lets an invalidate beat an LL completing in the same cycle
  assign snoop_link_hit = ccinv && link_valid_q &&
                          (link_addr_q == ccsnoopaddr[ADDR_W-1:WORD_LSB]);
  assign snoop_new_hit  = ccinv &&
                          (dmemaddr[ADDR_W-1:WORD_LSB] == ccsnoopaddr[ADDR_W-1:WORD_LSB]);
  logic unused_bits;
  assign unused_bits = ^{dmemaddr[WORD_LSB-1:0], ccsnoopaddr[WORD_LSB-1:0]};
`else
  assign snoop_link_hit = 1'b0;
  assign snoop_new_hit  = 1'b0;
  logic unused_bits;
  assign unused_bits = ^{dmemaddr[WORD_LSB-1:0], ccinv, ccsnoopaddr};
`endif

  always_comb begin
    state_d    = state_q;
    dmem_ren_d = dmem_ren_q;
    dmem_wen_d = dmem_wen_q;
    atomic_d   = atomic_q;
    halted_d   = halted_q;
    pc_en      = 1'b0;
    sc_result  = 1'b0;
    ll_done    = 1'b0;
    sc_retire  = 1'b0;

    case (state_q)
      FETCH: begin
        if (ihit) begin
          if (halt) begin
            state_d  = HALT;
            halted_d = 1'b1;
          end else if (dR_REQ || dW_REQ) begin
            if (dW_REQ && datomic && !link_ok) begin
              // SC without a live matching link retires immediately as a failure
              pc_en     = 1'b1;
              sc_retire = 1'b1;
            end else begin
              state_d    = DATA;
              dmem_ren_d = dR_REQ;
              dmem_wen_d = dW_REQ;
              atomic_d   = datomic;
            end
          end else begin
            pc_en = 1'b1;
          end
        end
      end
      DATA: begin
        if (dhit) begin
          pc_en      = 1'b1;
          state_d    = FETCH;
          dmem_ren_d = 1'b0;
          dmem_wen_d = 1'b0;
          ll_done    = atomic_q && dmem_ren_q;
          sc_retire  = atomic_q && dmem_wen_q;
          sc_result  = atomic_q && dmem_wen_q;
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = FETCH;
      end
    endcase

    link_valid_d = link_valid_q;
    link_addr_d  = link_addr_q;
    if (snoop_link_hit) link_valid_d = 1'b0;
    if (sc_retire)      link_valid_d = 1'b0;
    if (ll_done) begin
      link_valid_d = !snoop_new_hit;
      link_addr_d  = dmemaddr[ADDR_W-1:WORD_LSB];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= FETCH;
      dmem_ren_q   <= 1'b0;
      dmem_wen_q   <= 1'b0;
      atomic_q     <= 1'b0;
      halted_q     <= 1'b0;
      link_valid_q <= 1'b0;
      link_addr_q  <= '0;
    end else begin
      state_q      <= state_d;
      dmem_ren_q   <= dmem_ren_d;
      dmem_wen_q   <= dmem_wen_d;
      atomic_q     <= atomic_d;
      halted_q     <= halted_d;
      link_valid_q <= link_valid_d;
      link_addr_q  <= link_addr_d;
    end
  end

  assign imemREN    = (state_q == FETCH);
  assign dmemREN    = dmem_ren_q;
  assign dmemWEN    = dmem_wen_q;
  assign link_valid = link_valid_q;
  assign halted     = halted_q;

endmodule

// File: tb/tb_memory_request_unit.sv
// Randomized bench for memory_request_unit against an instruction-level model of fetch, data access and the LL/SC link.

module tb_memory_request_unit;

  localparam int NOP = 0, LW = 1, SW = 2, LL = 3, SC = 4;

  logic        CLK = 1'b0;
  logic        RST, ihit, dhit, dR_REQ, dW_REQ, datomic, halt, ccinv;
  logic [31:0] dmemaddr, ccsnoopaddr;
  logic        imemREN, dmemREN, dmemWEN, pc_en, sc_result, link_valid, halted;

  int n_checks = 0;
  int n_pass   = 0;

`ifdef LINK_SNOOP_EN
  bit snoop_on = 1'b1;
`else
  bit snoop_on = 1'b0;
`endif

  // model of the reservation: valid flag and linked address
  bit          m_valid;
  logic [31:0] m_addr;

  memory_request_unit dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .dR_REQ(dR_REQ), .dW_REQ(dW_REQ),
    .datomic(datomic), .halt(halt), .dmemaddr(dmemaddr), .ccinv(ccinv),
    .ccsnoopaddr(ccsnoopaddr), .imemREN(imemREN), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .pc_en(pc_en), .sc_result(sc_result), .link_valid(link_valid), .halted(halted)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic bit same_word(input logic [31:0] a, input logic [31:0] b);
    return a[31:2] == b[31:2];
  endfunction

  task automatic idle_inputs();
    ihit = 0; dhit = 0; dR_REQ = 0; dW_REQ = 0; datomic = 0; halt = 0; ccinv = 0;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    idle_inputs();
    RST = 1;
    @(negedge CLK);
    RST = 0;
    #2;
    m_valid = 0;
    check("rst_imemREN", imemREN, 1);
    check("rst_dmemREN", dmemREN, 0);
    check("rst_dmemWEN", dmemWEN, 0);
    check("rst_pc_en", pc_en, 0);
    check("rst_link_valid", link_valid, 0);
    check("rst_halted", halted, 0);
  endtask

  // One instruction: iwait fetch-stall cycles, ihit, then (if it accesses memory) dwait stall cycles and dhit.
  task automatic run_instr(input int kind, input logic [31:0] addr, input int iwait, input int dwait,
                           input bit snoop_fetch, input logic [31:0] snaddr, input bit snoop_dhit);
    bit rd, wr, sc_fail, access;
    rd = (kind == LW) || (kind == LL);
    wr = (kind == SW) || (kind == SC);
    if (snoop_fetch && iwait == 0) iwait = 1;
    for (int i = 0; i < iwait; i++) begin
      @(negedge CLK);
      idle_inputs();
      dhit = 1'($urandom_range(0, 1));
      dmemaddr = addr;
      ccinv = snoop_fetch && (i == 0);
      ccsnoopaddr = snaddr;
      #2;
      check("fw_imemREN", imemREN, 1);
      check("fw_dmemREN", dmemREN, 0);
      check("fw_dmemWEN", dmemWEN, 0);
      check("fw_pc_en", pc_en, 0);
      if (ccinv && snoop_on && m_valid && same_word(snaddr, m_addr)) m_valid = 0;
    end
    @(negedge CLK);
    idle_inputs();
    ihit = 1; dR_REQ = rd; dW_REQ = wr; datomic = (kind == LL) || (kind == SC);
    dhit = 1'($urandom_range(0, 1));
    dmemaddr = addr;
    #2;
    sc_fail = (kind == SC) && !(m_valid && same_word(addr, m_addr));
    access  = (kind != NOP) && !sc_fail;
    check("ih_pc_en", pc_en, !access);
    check("ih_sc_result", sc_result, 0);
    check("ih_imemREN", imemREN, 1);
    if (sc_fail) m_valid = 0;
    if (access) begin
      for (int d = 0; d <= dwait; d++) begin
        @(negedge CLK);
        idle_inputs();
        ihit = 1'($urandom_range(0, 1));
        dR_REQ = 1'($urandom_range(0, 1));
        dW_REQ = 1'($urandom_range(0, 1));
        datomic = 1'($urandom_range(0, 1));
        dhit = (d == dwait);
        ccinv = snoop_dhit && dhit;
        ccsnoopaddr = snaddr;
        #2;
        check("dt_imemREN", imemREN, 0);
        check("dt_dmemREN", dmemREN, rd);
        check("dt_dmemWEN", dmemWEN, wr);
        check("dt_pc_en", pc_en, dhit);
        check("dt_sc_result", sc_result, dhit && (kind == SC));
        if (dhit) begin
          if (kind == LL) begin
            m_valid = !(ccinv && snoop_on && same_word(snaddr, addr));
            m_addr  = addr;
          end else if (kind == SC) begin
            m_valid = 0;
          end else if (ccinv && snoop_on && m_valid && same_word(snaddr, m_addr)) begin
            m_valid = 0;
          end
        end
      end
    end
    @(negedge CLK);
    idle_inputs();
    #2;
    check("post_link_valid", link_valid, m_valid);
    check("post_imemREN", imemREN, 1);
    check("post_dmemREN", dmemREN, 0);
    check("post_dmemWEN", dmemWEN, 0);
    check("post_pc_en", pc_en, 0);
  endtask

  initial begin
    logic [31:0] addr_pool [6];
    addr_pool[0] = 32'h200; addr_pool[1] = 32'h204; addr_pool[2] = 32'h202;
    addr_pool[3] = 32'h300; addr_pool[4] = 32'h303; addr_pool[5] = 32'h100;
    RST = 1; idle_inputs(); dmemaddr = 0; ccsnoopaddr = 0; m_valid = 0; m_addr = 0;
    do_reset();

    run_instr(NOP, 32'h0,   0, 0, 0, 32'h0, 0);
    run_instr(LW,  32'h100, 0, 2, 0, 32'h0, 0);
    run_instr(LL,  32'h200, 1, 1, 0, 32'h0, 0);
    run_instr(SC,  32'h204, 0, 0, 0, 32'h0, 0);
    check("sc_mismatch_link", link_valid, 0);
    run_instr(LL,  32'h200, 0, 0, 0, 32'h0, 0);
    run_instr(SC,  32'h202, 0, 1, 0, 32'h0, 0);
    run_instr(LL,  32'h300, 0, 0, 0, 32'h0, 0);
    run_instr(SC,  32'h300, 2, 0, 1, 32'h300, 0);
    run_instr(LL,  32'h400, 0, 1, 0, 32'h400, 1);
    run_instr(LL,  32'h500, 0, 0, 0, 32'h0, 0);
    run_instr(SW,  32'h500, 0, 0, 0, 32'h0, 0);
    run_instr(SC,  32'h500, 0, 0, 0, 32'h0, 0);
    run_instr(LL,  32'h600, 0, 0, 0, 32'h0, 0);
    run_instr(SC,  32'h600, 0, 0, 0, 32'h600, 1);

    // reset in the middle of a data access abandons it
    @(negedge CLK);
    idle_inputs(); ihit = 1; dR_REQ = 1; dmemaddr = 32'h100;
    @(negedge CLK);
    idle_inputs(); RST = 1;
    #2;
    check("mid_dmemREN_before", dmemREN, 1);
    @(negedge CLK);
    RST = 0;
    #2;
    m_valid = 0;
    check("mid_dmemREN_after", dmemREN, 0);
    check("mid_imemREN_after", imemREN, 1);

    for (int n = 0; n < 250; n++) begin
      int kind;
      logic [31:0] a, s;
      kind = $urandom_range(0, 4);
      a = addr_pool[$urandom_range(0, 5)];
      s = addr_pool[$urandom_range(0, 5)];
      run_instr(kind, a, $urandom_range(0, 2), $urandom_range(0, 3),
                ($urandom_range(0, 3) == 0), s, ($urandom_range(0, 3) == 0));
    end

    @(negedge CLK);
    idle_inputs(); ihit = 1; halt = 1; dR_REQ = 1;
    #2;
    check("halt_pc_en", pc_en, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      idle_inputs();
      ihit = 1'($urandom_range(0, 1)); dhit = 1'($urandom_range(0, 1));
      dR_REQ = 1'($urandom_range(0, 1)); dW_REQ = 1'($urandom_range(0, 1));
      #2;
      check("halt_halted", halted, 1);
      check("halt_imemREN", imemREN, 0);
      check("halt_dmemREN", dmemREN, 0);
      check("halt_dmemWEN", dmemWEN, 0);
      check("halt_pc_en", pc_en, 0);
    end
    do_reset();
    run_instr(NOP, 32'h0, 0, 0, 0, 32'h0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/memory_request_unit.md
Name: memory_request_unit

Overview:
- Sits directly downstream of the instruction decode/control stage in each core's datapath.
- Consumes that stage's decoded memory-request, atomic and halt flags.
- Sequences instruction fetch and data access against the cache interface (ihit/dhit) and generates the PC-advance strobe.
- Owns the per-core LL/SC link register and the store-conditional success result.

Parameters:
ADDR_W, 32, width of memory addresses and of the link address register
WORD_LSB, 2, lowest address bit compared for link matching (word granularity)

Ports:
CLK  in  1  core clock
RST  in  1  synchronous active-high reset
ihit  in  1  instruction fetch complete this cycle
dhit  in  1  data access complete this cycle
dR_REQ  in  1  decoded instruction reads memory (LW/LL)
dW_REQ  in  1  decoded instruction writes memory (SW/SC)
datomic  in  1  decoded instruction is LL or SC
halt  in  1  decoded instruction is HALT
dmemaddr  in  ADDR_W  effective data address from ALU, held stable while pc_en is low
ccinv  in  1  coherence invalidate from the other core
ccsnoopaddr  in  ADDR_W  address of the coherence invalidate
imemREN  out  1  instruction read enable
dmemREN  out  1  data read enable
dmemWEN  out  1  data write enable
pc_en  out  1  PC advance / register-file write strobe, one cycle per retired instruction
sc_result  out  1  SC outcome (1 = success), valid in the cycle pc_en retires an SC
link_valid  out  1  LL reservation held
halted  out  1  core halted

Behaviour:
- Interface: one clock, CLK; reset is synchronous and active-high, RST.
- On reset:
  - state = FETCH; link_valid = 0; link_addr = 0; halted = 0.
  - All outputs low except imemREN = 1 in the cycle after RST deasserts.
- RST asserted mid-access drops dmemREN/dmemWEN on the next edge; the access is abandoned.
- State FETCH: imemREN = 1, dmemREN = dmemWEN = 0.
  - On ihit with halt = 1: go to HALT; pc_en = 0.
  - Else on ihit with dR_REQ | dW_REQ: latch the read/write type and atomic flag; go to DATA; pc_en = 0.
  - Exception: SC (dW_REQ & datomic) with link_valid = 0 or a link address mismatch fails fast. No memory access; pc_en = 1 and sc_result = 0 in the same cycle; stay in FETCH.
  - Else on ihit: pc_en = 1 combinationally in the same cycle; stay in FETCH.
  - dhit while in FETCH is ignored.
- State DATA: imemREN = 0; dmemREN = latched read, dmemWEN = latched write (both registered, asserted from the first DATA cycle).
  - Hold until dhit, with no timeout; ihit is ignored.
  - On dhit: pc_en = 1 in the same cycle; next state FETCH; REN/WEN low on the next cycle.
  - LL completing: link_valid <= 1, link_addr <= dmemaddr.
  - SC completing: sc_result = 1 in the dhit cycle; link_valid <= 0.
- State HALT: absorbing until RST. halted = 1 (registered); imemREN = dmemREN = dmemWEN = pc_en = 0.
- Link match: link_addr[ADDR_W-1:WORD_LSB] == address[ADDR_W-1:WORD_LSB]; byte offset ignored.
- Link clear sources:
  - RST.
  - SC retire, success or fail-fast.
  - Snoop, when the feature is enabled: ccinv & link_valid & match(ccsnoopaddr).
- Simultaneous events:
  - Snoop invalidate matching dmemaddr in the same cycle as an LL dhit: the invalidate wins and link_valid ends 0.
  - Snoop invalidate in the SC dhit cycle: the SC still succeeds, since the cache already granted exclusive.
- A plain SW to the linked word by this core does not clear the link.
- Exactly one pc_en pulse per retired instruction; pc_en is never high in two consecutive cycles for the same instruction.

Optional Feature:
- Macro LINK_SNOOP_EN.
- Defined: coherence invalidates clear a matching link as above (multicore build).
- Undefined: ccinv and ccsnoopaddr are ignored; the link is cleared only by RST and SC retire (single-core build).
- Port list is identical in both builds.

Test Plan:
- Reset then ihit with no request flags → pc_en = 1 in the ihit cycle; imemREN stays 1; dmemREN = dmemWEN = 0.
- ihit with dR_REQ = 1, dmemaddr = 0x100, dhit three cycles later → dmemREN high for exactly those cycles; imemREN = 0; single pc_en on the dhit cycle.
- LL to 0x200, then SC to 0x204 → SC fails fast: sc_result = 0, pc_en in the ihit cycle, dmemWEN never asserted, link_valid = 0.
- LL to 0x200, then SC to 0x202 → dmemWEN asserted, sc_result = 1 on dhit, link_valid = 0 afterwards.
- LL to 0x300, then ccinv with ccsnoopaddr = 0x300, then SC to 0x300:
  - With LINK_SNOOP_EN: SC fails with sc_result = 0.
  - Without LINK_SNOOP_EN: SC succeeds with sc_result = 1.
- ihit with halt = 1 → halted = 1 next cycle; all enables 0 despite further ihit/dhit; RST returns to FETCH with imemREN = 1.
